// File: rtl/clock_display_shifter.sv
// clock_display_shifter: snapshots six BCD time digits and shifts them out
// as 48 segment bits into a chain of 74HC595s. A storage-latch pulse follows.
module clock_display_shifter #(
    parameter int unsigned CLK_DIV            = 1,
    parameter bit          SEG_ACTIVE_LOW     = 1'b0,
    parameter bit          BLANK_LEADING_ZERO = 1'b1
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [3:0] hours_high_i,
    input  logic [3:0] hours_low_i,
    input  logic [3:0] minutes_high_i,
    input  logic [3:0] minutes_low_i,
    input  logic [3:0] seconds_high_i,
    input  logic [3:0] seconds_low_i,
    input  logic       valid_i,
    output logic       ready_o,
    output logic       sr_data_o,
    output logic       sr_clk_o,
    output logic       sr_latch_o,
    output logic       sr_oe_no
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT_LOW,
        SHIFT_HIGH,
        LATCH
    } state_e;

    localparam logic [7:0] PHASE_LAST = 8'(CLK_DIV - 1);
    localparam logic [5:0] LAST_BIT   = 6'd47;

    state_e      state_q, state_d;
    logic [7:0]  presc_q, presc_d;
    logic [5:0]  bitcnt_q, bitcnt_d;
    logic [47:0] shreg_q, shreg_d;
    logic        ready_q, ready_d;
    logic        data_q, data_d;
    logic        sclk_q, sclk_d;
    logic        latch_q, latch_d;
    logic        oe_n_q, oe_n_d;

    logic [47:0] frame_word;
    logic        phase_end;

    // {dp,g,f,e,d,c,b,a}; anything outside 0..9 shows a dash
    function automatic logic [7:0] seg_decode(input logic [3:0] digit);
        logic [7:0] seg;
        case (digit)
            4'd0:    seg = 8'h3F;
            4'd1:    seg = 8'h06;
            4'd2:    seg = 8'h5B;
            4'd3:    seg = 8'h4F;
            4'd4:    seg = 8'h66;
            4'd5:    seg = 8'h6D;
            4'd6:    seg = 8'h7D;
            4'd7:    seg = 8'h07;
            4'd8:    seg = 8'h7F;
            4'd9:    seg = 8'h6F;
            default: seg = 8'h40;
        endcase
        return seg;
    endfunction

    // Build the frame from the live digits; it is only sampled on acceptance
    always_comb begin
        logic       colon_on;
        logic [7:0] hh_byte;
        colon_on = ~seconds_low_i[0];
        hh_byte  = (BLANK_LEADING_ZERO && (hours_high_i == 4'd0)) ? 8'h00
                                                                   : seg_decode(hours_high_i);
        frame_word = {hh_byte,
                      seg_decode(hours_low_i)   | {colon_on, 7'b0},
                      seg_decode(minutes_high_i),
                      seg_decode(minutes_low_i) | {colon_on, 7'b0},
                      seg_decode(seconds_high_i),
                      seg_decode(seconds_low_i)};
        if (SEG_ACTIVE_LOW) begin
            frame_word = ~frame_word;
        end
    end

    assign phase_end = (presc_q == PHASE_LAST);

    // Next-state logic; output values are computed here and registered
    always_comb begin
        state_d  = state_q;
        presc_d  = presc_q;
        bitcnt_d = bitcnt_q;
        shreg_d  = shreg_q;
        ready_d  = ready_q;
        data_d   = data_q;
        sclk_d   = sclk_q;
        latch_d  = latch_q;
        oe_n_d   = oe_n_q;

        case (state_q)
            IDLE: begin
                if (valid_i && ready_q) begin
                    shreg_d  = frame_word;
                    bitcnt_d = '0;
                    presc_d  = '0;
                    ready_d  = 1'b0;
                    data_d   = frame_word[47];
                    sclk_d   = 1'b0;
                    state_d  = SHIFT_LOW;
                end
            end
            SHIFT_LOW: begin
                if (phase_end) begin
                    presc_d = '0;
                    sclk_d  = 1'b1;
                    state_d = SHIFT_HIGH;
                end else begin
                    presc_d = presc_q + 8'd1;
                end
            end
            SHIFT_HIGH: begin
                if (phase_end) begin
                    presc_d  = '0;
                    shreg_d  = {shreg_q[46:0], 1'b0};
                    bitcnt_d = bitcnt_q + 6'd1;
                    sclk_d   = 1'b0;
                    if (bitcnt_q == LAST_BIT) begin
                        data_d  = 1'b0;
                        latch_d = 1'b1;
                        state_d = LATCH;
                    end else begin
                        // data for the next low phase is the bit after the shift
                        data_d  = shreg_q[46];
                        state_d = SHIFT_LOW;
                    end
                end else begin
                    presc_d = presc_q + 8'd1;
                end
            end
            LATCH: begin
                if (phase_end) begin
                    presc_d = '0;
                    latch_d = 1'b0;
                    ready_d = 1'b1;
                    oe_n_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    presc_d = presc_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with asynchronous active-low reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            presc_q  <= '0;
            bitcnt_q <= '0;
            shreg_q  <= '0;
            ready_q  <= 1'b1;
            data_q   <= 1'b0;
            sclk_q   <= 1'b0;
            latch_q  <= 1'b0;
            oe_n_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            bitcnt_q <= bitcnt_d;
            shreg_q  <= shreg_d;
            ready_q  <= ready_d;
            data_q   <= data_d;
            sclk_q   <= sclk_d;
            latch_q  <= latch_d;
            oe_n_q   <= oe_n_d;
        end
    end

    assign ready_o    = ready_q;
    assign sr_data_o  = data_q;
    assign sr_clk_o   = sclk_q;
    assign sr_latch_o = latch_q;
    assign sr_oe_no   = oe_n_q;

endmodule

// File: tb/tb_clock_display_shifter.sv
// Bench for clock_display_shifter: three configurations, scoreboard of
// expected frames checked against the bits seen on shift-clock rising edges.
module tb_clock_display_shifter;

    typedef struct packed {
        logic [1:0]  inst;
        logic [47:0] word;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [23:0] digits [3];
    logic        valid  [3];
    logic        ready  [3];
    logic        sdata  [3];
    logic        sclk   [3];
    logic        latch  [3];
    logic        oe_n   [3];
    int          bits_seen [3];

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] seg_of(input logic [3:0] d);
        logic [7:0] table_v [16];
        table_v = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                    8'h7F, 8'h6F, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40};
        return table_v[d];
    endfunction

    function automatic logic [47:0] model(input int i, input logic [23:0] d);
        logic [47:0] w;
        logic [7:0]  dp;
        bit          blank;
        dp    = d[0] ? 8'h00 : 8'h80;
        blank = (i != 2);
        w[47:40] = (blank && d[23:20] == 4'd0) ? 8'h00 : seg_of(d[23:20]);
        w[39:32] = seg_of(d[19:16]) | dp;
        w[31:24] = seg_of(d[15:12]);
        w[23:16] = seg_of(d[11:8]) | dp;
        w[15:8]  = seg_of(d[7:4]);
        w[7:0]   = seg_of(d[3:0]);
        return (i == 1) ? ~w : w;
    endfunction

    // inst 0: defaults; inst 1: CLK_DIV=3, active-low; inst 2: no leading-zero blanking
    for (genvar g = 0; g < 3; g++) begin : g_inst
        localparam int unsigned DIVG = (g == 1) ? 3 : 1;

        clock_display_shifter #(
            .CLK_DIV           (DIVG),
            .SEG_ACTIVE_LOW    (g == 1),
            .BLANK_LEADING_ZERO(g != 2)
        ) u_dut (
            .clk_i         (clk),
            .rst_ni        (rst_n),
            .hours_high_i  (digits[g][23:20]),
            .hours_low_i   (digits[g][19:16]),
            .minutes_high_i(digits[g][15:12]),
            .minutes_low_i (digits[g][11:8]),
            .seconds_high_i(digits[g][7:4]),
            .seconds_low_i (digits[g][3:0]),
            .valid_i       (valid[g]),
            .ready_o       (ready[g]),
            .sr_data_o     (sdata[g]),
            .sr_clk_o      (sclk[g]),
            .sr_latch_o    (latch[g]),
            .sr_oe_no      (oe_n[g])
        );

        // Monitor: collect the serial stream and measure phase/latch/ready timing
        initial begin
            int          hicnt, locnt, latchcnt, rdylo, frames;
            logic        pclk, platch, prdy;
            logic [47:0] shw;
            exp_t        e;
            hicnt = 0; locnt = 0; latchcnt = 0; rdylo = 0; frames = 0;
            pclk = 1'b0; platch = 1'b0; prdy = 1'b1; shw = '0;
            bits_seen[g] = 0;
            forever begin
                @(negedge clk);
                if (!rst_n) begin
                    hicnt = 0; locnt = 0; latchcnt = 0; rdylo = 0; frames = 0;
                    pclk = 1'b0; platch = 1'b0; prdy = 1'b1; shw = '0;
                    bits_seen[g] = 0;
                    sb_q.delete();
                end else begin
                    if (sclk[g] && !pclk) begin
                        if (bits_seen[g] > 0) check_eq("low_phase", 64'(locnt), 64'(DIVG));
                        shw = {shw[46:0], sdata[g]};
                        bits_seen[g]++;
                        hicnt = 0;
                    end
                    if (!sclk[g] && pclk) begin
                        check_eq("high_phase", 64'(hicnt), 64'(DIVG));
                        locnt = 0;
                    end
                    if (sclk[g]) hicnt++;
                    else if (!latch[g]) locnt++;

                    if (latch[g] && !platch) begin
                        check_eq("bit_count", 64'(bits_seen[g]), 64'd48);
                        check_eq("oe_before_latch", 64'(oe_n[g]), (frames == 0) ? 64'd1 : 64'd0);
                        check_eq("sb_pending", 64'(sb_q.size() > 0), 64'd1);
                        if (sb_q.size() > 0) begin
                            e = sb_q.pop_front();
                            check_eq("sb_inst", 64'(e.inst), 64'(g));
                            check_eq("frame", 64'(shw), 64'(e.word));
                        end
                        latchcnt = 0;
                    end
                    if (latch[g]) latchcnt++;
                    if (!latch[g] && platch) begin
                        check_eq("latch_width", 64'(latchcnt), 64'(DIVG));
                        check_eq("oe_after_latch", 64'(oe_n[g]), 64'd0);
                        frames++;
                        bits_seen[g] = 0;
                        shw = '0;
                    end

                    if (!ready[g]) rdylo++;
                    if (ready[g] && !prdy) begin
                        check_eq("ready_low", 64'(rdylo), 64'(97 * DIVG));
                        rdylo = 0;
                    end

                    pclk   = sclk[g];
                    platch = latch[g];
                    prdy   = ready[g];
                end
            end
        end
    end

    task automatic wait_ready(input int i);
        int n;
        n = 0;
        while (ready[i] !== 1'b1 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) check_eq("ready_timeout", 64'(ready[i]), 64'd1);
    endtask

    task automatic send(input int i, input logic [23:0] d, input logic [47:0] w);
        exp_t e;
        wait_ready(i);
        digits[i] = d;
        valid[i]  = 1'b1;
        e.inst    = 2'(i);
        e.word    = w;
        sb_q.push_back(e);
        @(negedge clk);
        valid[i] = 1'b0;
    endtask

    task automatic wait_idle(input int i);
        int n;
        n = 0;
        while ((sb_q.size() != 0 || ready[i] !== 1'b1) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) check_eq("idle_timeout", 64'(sb_q.size()), 64'd0);
        @(negedge clk);
    endtask

    task automatic check_reset_values(input int i);
        check_eq("rst_ready", 64'(ready[i]), 64'd1);
        check_eq("rst_data",  64'(sdata[i]), 64'd0);
        check_eq("rst_sclk",  64'(sclk[i]),  64'd0);
        check_eq("rst_latch", 64'(latch[i]), 64'd0);
        check_eq("rst_oe_n",  64'(oe_n[i]),  64'd1);
    endtask

    function automatic logic [23:0] rand_time();
        return {4'($urandom_range(0, 2)), 4'($urandom_range(0, 9)),
                4'($urandom_range(0, 5)), 4'($urandom_range(0, 9)),
                4'($urandom_range(0, 5)), 4'($urandom_range(0, 9))};
    endfunction

    initial begin
        logic [23:0] d;
        int          n;
        for (int i = 0; i < 3; i++) begin
            digits[i] = '0;
            valid[i]  = 1'b0;
        end
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) check_reset_values(i);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;

        // basic frame and the odd-seconds / leading-zero cases
        send(0, 24'h123456, 48'h06DB4FE66D7D);
        wait_idle(0);
        send(0, 24'h095959, 48'h006F6D6F6D6F);
        wait_idle(0);
        send(2, 24'h095959, 48'h3F6F6D6F6D6F);
        wait_idle(2);

        // invalid BCD decodes to a dash, dp still applied on hl
        send(0, 24'h0C0000, 48'h00C03FBF3F3F);
        wait_idle(0);
        send(0, 24'hFABCDE, 48'h40C040C04040);
        wait_idle(0);

        // active-low inversion
        send(1, 24'h000000, 48'hFF40C040C0C0);
        wait_idle(1);

        // slow shift clock, digits and valid toggling while busy
        send(1, 24'h123456, ~48'h06DB4FE66D7D);
        repeat (60) begin
            @(negedge clk);
            digits[1] = 24'($urandom);
            valid[1]  = 1'($urandom_range(0, 1));
        end
        valid[1] = 1'b0;
        wait_idle(1);
        repeat (20) @(negedge clk);
        check_eq("no_extra_frame", 64'(ready[1]), 64'd1);

        // back-to-back with valid held high
        d = 24'h235958;
        wait_ready(0);
        digits[0] = 24'h101010;
        valid[0]  = 1'b1;
        sb_q.push_back('{inst: 2'd0, word: model(0, 24'h101010)});
        @(negedge clk);
        digits[0] = d;
        sb_q.push_back('{inst: 2'd0, word: model(0, d)});
        n = 0;
        while (ready[0] !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check_eq("b2b_gap", 64'(ready[0]), 64'd0);
        valid[0] = 1'b0;
        wait_idle(0);

        // randomised valid times on every configuration
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 3; i++) begin
                d = rand_time();
                send(i, d, model(i, d));
                wait_idle(i);
            end
        end

        // reset in the middle of a frame, then a clean frame
        send(0, 24'h121212, model(0, 24'h121212));
        n = 0;
        while (bits_seen[0] < 20 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check_eq("reached_20_bits", 64'(bits_seen[0] >= 20), 64'd1);
        #2 rst_n = 1'b0;
        #1 check_reset_values(0);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        send(0, 24'h204837, model(0, 24'h204837));
        wait_idle(0);
        send(0, 24'h000102, 48'h00BF3F863F5B);
        wait_idle(0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "timeout");
    end

endmodule
